chunked_addsub: RTL and testbench

- Parametrised multi-cycle add/subtract unit; successor to the team's fixed 2-bit combinational adder.
- Processes CHUNK bits per clock through a registered carry, so wide operands cost few adder cells.
- Uses ready/valid on both input and output, so it can sit between lab datapath stages such as the register file and the display or accumulator logic.

---
 rtl/chunked_addsub.sv | 108 ++++++++++
 tb/tb_chunked_addsub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: CHUNK bits per RUN cycle through a registered carry,
// ready/valid on both sides, one operation in flight at a time.
module chunked_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0]   y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] ca, cb;
    logic [CHUNK:0]   csum;
    logic             last, cin_msb;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a DONE handshake only retires the result, never accepts
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign ca      = a_q[cnt_q*CHUNK +: CHUNK];
    assign cb      = b_q[cnt_q*CHUNK +: CHUNK];
    assign csum    = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
    assign last    = (cnt_q == CW'(N - 1));
    // Carry into the MSB recovered from the MSB's own sum bit
    assign cin_msb = ca[CHUNK-1] ^ cb[CHUNK-1] ^ csum[CHUNK-1];

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            y_d[cnt_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
            carry_d = csum[CHUNK];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                y_d[WIDTH] = csum[CHUNK];
                ovf_d      = cin_msb ^ csum[CHUNK];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y   = y_q;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: three configurations (8/2, 8/8, 16/4), directed table,
// backpressure and mid-RUN reset sequences, random vectors against an arithmetic model.
module tb_chunked_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv = '0, sb = '0, ordy = '0;
    logic [15:0] a_s [3];
    logic [15:0] b_s [3];
    wire  [2:0]  ir, ovl, of;
    wire  [8:0]  y0, y1;
    wire  [16:0] y2;

    int errors = 0, checks = 0;
    int wid [3] = '{8, 8, 16};
    int nch [3] = '{4, 1, 4};

    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(8), .CHUNK(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]), .sub(sb[0]),
        .out_valid(ovl[0]), .out_ready(ordy[0]), .y(y0), .ovf(of[0]));
    chunked_addsub #(.WIDTH(8), .CHUNK(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[1][7:0]), .b(b_s[1][7:0]), .sub(sb[1]),
        .out_valid(ovl[1]), .out_ready(ordy[1]), .y(y1), .ovf(of[1]));
    chunked_addsub #(.WIDTH(16), .CHUNK(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s[2]), .b(b_s[2]), .sub(sb[2]),
        .out_valid(ovl[2]), .out_ready(ordy[2]), .y(y2), .ovf(of[2]));

    function automatic logic [16:0] y_of(input int d);
        case (d)
            0:       return {8'b0, y0};
            1:       return {8'b0, y1};
            default: return y2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on w-bit operands
    function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                  input logic sv, output logic [16:0] ye, output logic oe);
        longint m  = longint'(1) << w;
        longint ua = longint'(av) & (m - 1);
        longint ub = longint'(bv) & (m - 1);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sbv = (ub >= m / 2) ? ub - m : ub;
        longint r;
        longint u;
        if (sv) begin
            u = ((ua - ub) % m + m) % m + ((ua >= ub) ? m : 0);
            r = sa - sbv;
        end else begin
            u = ua + ub;
            r = sa + sbv;
        end
        ye = 17'(u);
        oe = (r < -(m / 2)) || (r >= m / 2);
    endfunction

    // One full transaction on DUT d; returns result and accept-to-out_valid latency
    task automatic do_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, output logic [16:0] yv, output logic ovv,
                         output int lat);
        int t = 0;
        @(negedge clk);
        a_s[d] = av; b_s[d] = bv; sb[d] = sv; iv[d] = 1'b1;
        while (!ir[d] && t < 100) begin @(negedge clk); t++; end
        chk("accept_timeout", 32'(t >= 100), 32'd0);
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        a_s[d] = 16'($urandom); b_s[d] = 16'($urandom); sb[d] = 1'($urandom);
        lat = 0;
        while (!ovl[d] && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            chk("busy_in_ready", 32'(ir[d]), 32'd0);
        end
        yv  = y_of(d);
        ovv = of[d];
        @(negedge clk);
        ordy[d] = 1'b1;
        @(posedge clk);
        #1;
        ordy[d] = 1'b0;
        chk("post_xfer_valid", 32'(ovl[d]), 32'd0);
        chk("post_xfer_ready", 32'(ir[d]), 32'd1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [8:0] y;
        logic       o;
    } vec_t;

    initial begin
        vec_t        tbl [7];
        logic [16:0] yv, ye, yh;
        logic        ovv, oe, oh;
        int          lat, t;

        tbl[0] = '{8'h03, 8'h02, 1'b0, 9'h005, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1};
        tbl[3] = '{8'h05, 8'h07, 1'b1, 9'h0FE, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 9'h17F, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 9'h100, 1'b0};
        tbl[6] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1};
        for (int d = 0; d < 3; d++) begin a_s[d] = '0; b_s[d] = '0; end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_in_ready", 32'(ir[d]), 32'd1);
            chk("reset_out_valid", 32'(ovl[d]), 32'd0);
            chk("reset_y", 32'(y_of(d)), 32'd0);
            chk("reset_ovf", 32'(of[d]), 32'd0);
        end

        foreach (tbl[i]) begin
            do_op(0, 16'(tbl[i].a), 16'(tbl[i].b), tbl[i].s, yv, ovv, lat);
            chk($sformatf("tbl%0d_y", i), 32'(yv), 32'(tbl[i].y));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovv), 32'(tbl[i].o));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd4);
        end
        do_op(1, 16'hFF, 16'h01, 1'b0, yv, ovv, lat);
        chk("w8c8_y", 32'(yv), 32'h100);
        chk("w8c8_lat", 32'(lat), 32'd1);
        do_op(2, 16'h7FFF, 16'h0001, 1'b0, yv, ovv, lat);
        chk("w16c4_y", 32'(yv), 32'h08000);
        chk("w16c4_ovf", 32'(ovv), 32'd1);

        // Backpressure: hold result while in_valid pulses, then handshake
        @(negedge clk);
        a_s[0] = 16'h12; b_s[0] = 16'h34; sb[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        t = 0;
        while (!ovl[0] && t < 20) begin @(posedge clk); #1; t++; end
        chk("bp_lat", 32'(t), 32'd4);
        yh = y_of(0); oh = of[0];
        chk("bp_y", 32'(yh), 32'h046);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            iv[0] = (k != 1); a_s[0] = 16'hAA; b_s[0] = 16'h55;
            @(posedge clk);
            #1;
            chk("bp_hold_y", 32'(y_of(0)), 32'(yh));
            chk("bp_hold_ovf", 32'(of[0]), 32'(oh));
            chk("bp_hold_valid", 32'(ovl[0]), 32'd1);
            chk("bp_hold_ready", 32'(ir[0]), 32'd0);
        end
        @(negedge clk);
        iv[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        chk("bp_done_valid", 32'(ovl[0]), 32'd0);
        chk("bp_idle_ready", 32'(ir[0]), 32'd1);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("bp_accept", 32'(ir[0]), 32'd0);
        t = 0;
        while (!ovl[0] && t < 20) begin @(posedge clk); #1; t++; end
        chk("bp2_lat", 32'(t), 32'd4);
        chk("bp2_y", 32'(y_of(0)), 32'h0FF);
        chk("bp2_ovf", 32'(of[0]), 32'd0);
        @(negedge clk); ordy[0] = 1'b1;
        @(posedge clk); #1; ordy[0] = 1'b0;

        // Reset two chunks into RUN
        @(negedge clk);
        chk("rst_pre_idle", 32'(ir[0]), 32'd1);
        a_s[0] = 16'hAB; b_s[0] = 16'h11; sb[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(ovl[0]), 32'd0);
        chk("rst_mid_y", 32'(y_of(0)), 32'd0);
        chk("rst_mid_ovf", 32'(of[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", 32'(ir[0]), 32'd1);
        chk("rst_rel_valid", 32'(ovl[0]), 32'd0);
        do_op(0, 16'h10, 16'h20, 1'b0, yv, ovv, lat);
        chk("rst_fresh_y", 32'(yv), 32'h030);
        chk("rst_fresh_lat", 32'(lat), 32'd4);

        // Random sweep, 1000 vectors per mode per configuration
        for (int d = 0; d < 3; d++) begin
            for (int md = 0; md < 2; md++) begin
                for (int n = 0; n < 1000; n++) begin
                    logic [15:0] av, bv;
                    av = 16'($urandom);
                    bv = 16'($urandom);
                    if (wid[d] == 8) begin av[15:8] = '0; bv[15:8] = '0; end
                    do_op(d, av, bv, 1'(md), yv, ovv, lat);
                    model(wid[d], av, bv, 1'(md), ye, oe);
                    chk($sformatf("rnd_d%0d_y", d), 32'(yv), 32'(ye));
                    chk($sformatf("rnd_d%0d_ovf", d), 32'(ovv), 32'(oe));
                    chk($sformatf("rnd_d%0d_lat", d), 32'(lat), 32'(nch[d]));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
